// File: rtl/debounce_filter.sv
// debounce_filter: multi-channel debounce for slow discrete inputs.
// Each channel is synchronised, sampled on a shared prescaled tick and
// filtered by a saturating run counter. Outputs are a filtered level,
// single-cycle rise/fall pulses, a combined change pulse and a sticky
// glitch flag per channel.
module debounce_filter #(
  parameter int                          NUMBER_SIGNALS   = 4,
  parameter int                          CLOCK_PERIOD_NS  = 20,
  parameter int                          SAMPLE_PERIOD_NS = 500_000,
  parameter int                          STABLE_SAMPLES   = 8,
  parameter int                          SYNC_STAGES      = 2,
  parameter logic [NUMBER_SIGNALS-1:0]   RESET_VALUE      = '1
) (
  input  logic                      clk_i,
  input  logic                      nReset_i,
  input  logic                      enable_i,
  input  logic                      clear_i,
  input  logic [NUMBER_SIGNALS-1:0] signals_i,
  output logic [NUMBER_SIGNALS-1:0] signals_o,
  output logic [NUMBER_SIGNALS-1:0] rise_o,
  output logic [NUMBER_SIGNALS-1:0] fall_o,
  output logic                      changed_o,
  output logic [NUMBER_SIGNALS-1:0] glitch_o
);

  localparam int SAMPLE_DIV = SAMPLE_PERIOD_NS / CLOCK_PERIOD_NS;
  localparam int CNT_W      = $clog2(STABLE_SAMPLES + 1);

  localparam logic [CNT_W-1:0]          CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]          CNT_ONE  = CNT_W'(1);
  // Count value at which one more differing sample commits the change.
  localparam logic [CNT_W-1:0]          CNT_LAST = CNT_W'(STABLE_SAMPLES - 1);
  localparam logic [NUMBER_SIGNALS-1:0] VEC_ZERO = {NUMBER_SIGNALS{1'b0}};

  logic [NUMBER_SIGNALS-1:0] sync_r [SYNC_STAGES];
  logic [NUMBER_SIGNALS-1:0] sync_s;
  logic                      tick_s;
  logic [CNT_W-1:0]          cnt_r     [NUMBER_SIGNALS];
  logic [CNT_W-1:0]          cnt_nxt_s [NUMBER_SIGNALS];
  logic [NUMBER_SIGNALS-1:0] out_nxt_s;
  logic [NUMBER_SIGNALS-1:0] rise_nxt_s;
  logic [NUMBER_SIGNALS-1:0] fall_nxt_s;
  logic [NUMBER_SIGNALS-1:0] gset_s;
  logic [NUMBER_SIGNALS-1:0] glitch_nxt_s;
  logic                      clear_d_r;
  logic                      clear_edge_s;

  // Input synchroniser chain; the last stage feeds the filters.
  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      for (int s = 0; s < SYNC_STAGES; s++) begin
        sync_r[s] <= RESET_VALUE;
      end
    end else begin
      sync_r[0] <= signals_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        sync_r[s] <= sync_r[s-1];
      end
    end
  end

  assign sync_s = sync_r[SYNC_STAGES-1];

  if (SAMPLE_DIV <= 1) begin : g_no_prescaler
    assign tick_s = enable_i;
  end else begin : g_prescaler
    localparam int                PRE_W    = $clog2(SAMPLE_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(SAMPLE_DIV - 1);
    localparam logic [PRE_W-1:0]  PRE_ONE  = PRE_W'(1);
    logic [PRE_W-1:0] pre_cnt_r;

    // Prescaler: advances only while enabled, wraps on the tick cycle.
    always_ff @(posedge clk_i or negedge nReset_i) begin
      if (!nReset_i) begin
        pre_cnt_r <= {PRE_W{1'b0}};
      end else if (enable_i) begin
        if (pre_cnt_r == PRE_LAST) begin
          pre_cnt_r <= {PRE_W{1'b0}};
        end else begin
          pre_cnt_r <= pre_cnt_r + PRE_ONE;
        end
      end else begin
        pre_cnt_r <= pre_cnt_r;
      end
    end

    assign tick_s = enable_i && (pre_cnt_r == PRE_LAST);
  end

  assign clear_edge_s = clear_i & ~clear_d_r;

  // Per-channel filter decision and glitch flag next state.
  always_comb begin
    out_nxt_s  = signals_o;
    rise_nxt_s = VEC_ZERO;
    fall_nxt_s = VEC_ZERO;
    gset_s     = VEC_ZERO;
    for (int i = 0; i < NUMBER_SIGNALS; i++) begin
      cnt_nxt_s[i] = cnt_r[i];
      if (tick_s) begin
        if (sync_s[i] == signals_o[i]) begin
          // Run of differing samples broken: a pending change was a bounce.
          cnt_nxt_s[i] = CNT_ZERO;
          if (cnt_r[i] != CNT_ZERO) begin
            gset_s[i] = 1'b1;
          end else begin
            gset_s[i] = 1'b0;
          end
        end else if (cnt_r[i] == CNT_LAST) begin
          out_nxt_s[i]  = sync_s[i];
          rise_nxt_s[i] = sync_s[i];
          fall_nxt_s[i] = ~sync_s[i];
          cnt_nxt_s[i]  = CNT_ZERO;
        end else begin
          cnt_nxt_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else begin
        cnt_nxt_s[i] = cnt_r[i];
      end
    end
    // A clear edge wipes old flags, but a bounce seen this cycle survives it.
    if (clear_edge_s) begin
      glitch_nxt_s = gset_s;
    end else begin
      glitch_nxt_s = glitch_o | gset_s;
    end
  end

  // Registered outputs, run counters and clear edge detector.
  always_ff @(posedge clk_i or negedge nReset_i) begin
    if (!nReset_i) begin
      signals_o <= RESET_VALUE;
      rise_o    <= VEC_ZERO;
      fall_o    <= VEC_ZERO;
      changed_o <= 1'b0;
      glitch_o  <= VEC_ZERO;
      clear_d_r <= 1'b0;
      for (int i = 0; i < NUMBER_SIGNALS; i++) begin
        cnt_r[i] <= CNT_ZERO;
      end
    end else begin
      signals_o <= out_nxt_s;
      rise_o    <= rise_nxt_s;
      fall_o    <= fall_nxt_s;
      changed_o <= |(rise_nxt_s | fall_nxt_s);
      glitch_o  <= glitch_nxt_s;
      clear_d_r <= clear_i;
      for (int i = 0; i < NUMBER_SIGNALS; i++) begin
        cnt_r[i] <= cnt_nxt_s[i];
      end
    end
  end

endmodule

// File: tb/tb_debounce_filter.sv
// Self-checking bench for debounce_filter with a tick-level reference model.
module tb_debounce_filter;

  localparam int DIV = 5;
  localparam int SS  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b1;
  logic       clr = 1'b0;
  logic [3:0] sig_in = 4'hF;
  logic [3:0] signals_o, rise_o, fall_o, glitch_o;
  logic       changed_o;

  int n_pass = 0;
  int n_total = 0;

  always #10 clk = ~clk;

  debounce_filter #(
    .NUMBER_SIGNALS(4), .CLOCK_PERIOD_NS(20), .SAMPLE_PERIOD_NS(100),
    .STABLE_SAMPLES(SS), .SYNC_STAGES(2), .RESET_VALUE(4'b1111)
  ) dut (
    .clk_i(clk), .nReset_i(rst_n), .enable_i(en), .clear_i(clr),
    .signals_i(sig_in), .signals_o(signals_o), .rise_o(rise_o),
    .fall_o(fall_o), .changed_o(changed_o), .glitch_o(glitch_o)
  );

  // Reference model: input seen by the filter is the raw input two clocks
  // old; a tick falls on every DIV-th enabled clock; a level changes once
  // SS consecutive tick samples disagree with it.
  logic [3:0] m_out, m_rise, m_fall, m_glitch, m_h0, m_h1;
  logic       m_chg, m_clr_prev;
  int         m_en_cnt;
  int         m_run [4];
  logic [3:0] n_out, n_rise, n_fall, n_glitch, n_gset;
  logic       n_tick;
  int         n_run [4];

  wire [16:0] dut_vec = {signals_o, rise_o, fall_o, changed_o, glitch_o};
  wire [16:0] mdl_vec = {m_out, m_rise, m_fall, m_chg, m_glitch};

  // Model next state from the sampling rules.
  always_comb begin
    n_tick = en && ((m_en_cnt % DIV) == DIV - 1);
    n_out  = m_out;
    n_rise = 4'h0;
    n_fall = 4'h0;
    n_gset = 4'h0;
    for (int i = 0; i < 4; i++) begin
      n_run[i] = m_run[i];
      if (n_tick) begin
        if (m_h1[i] != m_out[i]) begin
          n_run[i] = m_run[i] + 1;
          if (n_run[i] == SS) begin
            n_out[i]  = m_h1[i];
            n_rise[i] = m_h1[i];
            n_fall[i] = ~m_h1[i];
            n_run[i]  = 0;
          end
        end else begin
          n_gset[i] = (m_run[i] > 0);
          n_run[i]  = 0;
        end
      end
    end
    n_glitch = ((clr && !m_clr_prev) ? 4'h0 : m_glitch) | n_gset;
  end

  // Model state update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_out <= 4'hF; m_rise <= 4'h0; m_fall <= 4'h0; m_chg <= 1'b0;
      m_glitch <= 4'h0; m_h0 <= 4'hF; m_h1 <= 4'hF; m_clr_prev <= 1'b0;
      m_en_cnt <= 0;
      for (int i = 0; i < 4; i++) m_run[i] <= 0;
    end else begin
      m_out <= n_out; m_rise <= n_rise; m_fall <= n_fall;
      m_chg <= |(n_rise | n_fall); m_glitch <= n_glitch;
      m_h1 <= m_h0; m_h0 <= sig_in; m_clr_prev <= clr;
      if (en) m_en_cnt <= m_en_cnt + 1;
      for (int i = 0; i < 4; i++) m_run[i] <= n_run[i];
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_total++;
    if (dut_vec !== {4'hF, 13'h0000}) $display("FAIL reset_state: got %h expected %h", dut_vec, {4'hF, 13'h0000});
    else n_pass++;
    rst_n = 1'b1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== {4'hF, 13'h0000}) $display("FAIL idle_state cyc %0d: got %h expected %h", c, dut_vec, {4'hF, 13'h0000});
      else n_pass++;
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL idle_model cyc %0d: got %h expected %h", c, dut_vec, mdl_vec);
      else n_pass++;
    end
  endtask

  task automatic test_clean_edge();
    int lat = 0; int fcnt = 0; int ccnt = 0; bit found = 1'b0; bit rseen = 1'b0;
    sig_in[0] = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (!found) begin
        lat++;
        if (signals_o[0] == 1'b0) found = 1'b1;
      end
      if (fall_o[0]) fcnt++;
      if (changed_o) ccnt++;
      if (rise_o != 4'h0) rseen = 1'b1;
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL edge_model cyc %0d: got %h expected %h", c, dut_vec, mdl_vec);
      else n_pass++;
    end
    n_total++;
    if (!found || lat < 13 || lat > 17) $display("FAIL edge_latency: got %0d (found %0d) expected 13..17", lat, found);
    else n_pass++;
    n_total++;
    if (fcnt != 1) $display("FAIL edge_fall_width: got %0d expected 1", fcnt); else n_pass++;
    n_total++;
    if (ccnt != 1) $display("FAIL edge_changed_width: got %0d expected 1", ccnt); else n_pass++;
    n_total++;
    if (rseen) $display("FAIL edge_no_rise: got 1 expected 0"); else n_pass++;
  endtask

  task automatic test_bounce();
    logic [3:0] hold_v;
    sig_in[1] = 1'b0;
    repeat (7) @(negedge clk);
    sig_in[1] = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL bounce_model cyc %0d: got %h expected %h", c, dut_vec, mdl_vec);
      else n_pass++;
    end
    n_total++;
    if (signals_o[1] !== 1'b1) $display("FAIL bounce_level: got %b expected 1", signals_o[1]); else n_pass++;
    n_total++;
    if (glitch_o[1] !== 1'b1) $display("FAIL bounce_glitch: got %b expected 1", glitch_o[1]); else n_pass++;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_total++;
    if (glitch_o !== 4'h0) $display("FAIL glitch_clear: got %h expected 0", glitch_o); else n_pass++;
    // Random short bounces on random channels must never reach the output.
    for (int k = 0; k < 8; k++) begin
      int ch = $urandom_range(0, 3);
      int len = $urandom_range(1, 9);
      hold_v = signals_o;
      sig_in[ch] = ~sig_in[ch];
      repeat (len) @(negedge clk);
      sig_in[ch] = ~sig_in[ch];
      for (int c = 0; c < 12; c++) begin
        @(negedge clk);
        n_total++;
        if (dut_vec !== mdl_vec) $display("FAIL rand_bounce_model: got %h expected %h", dut_vec, mdl_vec);
        else n_pass++;
      end
      n_total++;
      if (signals_o !== hold_v) $display("FAIL rand_bounce_hold ch%0d len%0d: got %h expected %h", ch, len, signals_o, hold_v);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous();
    int f2 = -1; int f3 = -1; int ccnt = 0; logic [3:0] fpat = 4'h0;
    sig_in = 4'hF;
    repeat (25) @(negedge clk);
    sig_in[3:2] = 2'b00;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (fall_o[2]) begin f2 = c; fpat = fall_o; end
      if (fall_o[3]) f3 = c;
      if (changed_o) ccnt++;
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL simul_model cyc %0d: got %h expected %h", c, dut_vec, mdl_vec);
      else n_pass++;
    end
    n_total++;
    if (f2 < 0 || f2 != f3) $display("FAIL simul_same_cycle: got %0d/%0d expected equal", f2, f3); else n_pass++;
    n_total++;
    if (fpat !== 4'b1100) $display("FAIL simul_fall_pattern: got %b expected 1100", fpat); else n_pass++;
    n_total++;
    if (ccnt != 1) $display("FAIL simul_changed: got %0d expected 1", ccnt); else n_pass++;
  endtask

  task automatic test_enable_freeze();
    int waited = 0; int lat = 0; bit found = 1'b0;
    sig_in = 4'hF;
    repeat (25) @(negedge clk);
    sig_in[0] = 1'b0;
    while (m_run[0] != 2 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (m_run[0] != 2) $display("FAIL freeze_wait: got timeout expected two ticks"); else n_pass++;
    en = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      n_total++;
      if (signals_o[0] !== 1'b1 || changed_o !== 1'b0) $display("FAIL freeze_hold cyc %0d: got %b/%b expected 1/0", c, signals_o[0], changed_o);
      else n_pass++;
    end
    en = 1'b1;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      lat++;
      if (signals_o[0] == 1'b0) found = 1'b1;
    end
    n_total++;
    if (!found || lat != DIV) $display("FAIL freeze_resume: got %0d expected %0d", lat, DIV); else n_pass++;
    n_total++;
    if (fall_o !== 4'b0001) $display("FAIL freeze_pulse: got %b expected 0001", fall_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int waited = 0; int lat = 0; bit found = 1'b0; bit fseen = 1'b0;
    sig_in = 4'hF;
    repeat (25) @(negedge clk);
    sig_in[1] = 1'b0;
    while (m_run[1] != 2 && waited < 30) begin
      @(negedge clk);
      waited++;
    end
    n_total++;
    if (m_run[1] != 2) $display("FAIL rstmid_wait: got timeout expected two ticks"); else n_pass++;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_total++;
    if (dut_vec !== {4'hF, 13'h0000}) $display("FAIL rstmid_immediate: got %h expected %h", dut_vec, {4'hF, 13'h0000});
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      if (fall_o != 4'h0) fseen = 1'b1;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      lat++;
      if (fall_o != 4'h0 && signals_o[1] != 1'b0) fseen = 1'b1;
      if (signals_o[1] == 1'b0) found = 1'b1;
    end
    n_total++;
    if (fseen) $display("FAIL rstmid_no_pulse: got pulse expected none"); else n_pass++;
    n_total++;
    if (!found || lat != SS * DIV) $display("FAIL rstmid_restart: got %0d expected %0d", lat, SS * DIV); else n_pass++;
  endtask

  task automatic test_random();
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      n_total++;
      if (dut_vec !== mdl_vec) $display("FAIL random_model cyc %0d: got %h expected %h", c, dut_vec, mdl_vec);
      else n_pass++;
      if ($urandom_range(0, 7) == 0) begin
        int b = $urandom_range(0, 3);
        sig_in[b] = ~sig_in[b];
      end
      if ($urandom_range(0, 39) == 0) en = ~en;
      clr = ($urandom_range(0, 19) == 0);
    end
    en = 1'b1;
    clr = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_edge();
    test_bounce();
    test_simultaneous();
    test_enable_freeze();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/debounce_filter.md
# debounce_filter

Multi-channel debounce filter for slow discrete inputs such as limit switches, end stops and fault lines. Each input is synchronised, sampled on a shared prescaled tick and debounced by its own saturating counter. Each channel produces a filtered level, single-cycle rise/fall pulses and a sticky glitch flag. The block sits between the raw board inputs and the actuator control logic.

## Interface
- NUMBER_SIGNALS, 4, number of independent channels (≥1)
- CLOCK_PERIOD_NS, 20, clk_i period
- SAMPLE_PERIOD_NS, 500_000, sample tick period; SAMPLE_DIV = SAMPLE_PERIOD_NS / CLOCK_PERIOD_NS (integer division)
- STABLE_SAMPLES, 8, consecutive differing samples needed to change an output (≥1)
- SYNC_STAGES, 2, input synchroniser depth (≥2)
- RESET_VALUE, '1, NUMBER_SIGNALS-bit reset/initial level of filtered outputs and synchronisers
- clk_i  input  1  system clock
- nReset_i  input  1  reset, asynchronous, active-low
- enable_i  input  1  sampling enable; low freezes the prescaler and all counters
- clear_i  input  1  synchronous clear of glitch_o
- signals_i  input  NUMBER_SIGNALS  raw asynchronous inputs
- signals_o  output  NUMBER_SIGNALS  debounced levels
- rise_o  output  NUMBER_SIGNALS  1-clk pulse when signals_o[i] goes 0→1
- fall_o  output  NUMBER_SIGNALS  1-clk pulse when signals_o[i] goes 1→0
- changed_o  output  1  OR of rise_o | fall_o, registered in the same cycle
- glitch_o  output  NUMBER_SIGNALS  sticky: a rejected bounce occurred on channel i

## Operation
- Reset (nReset_i low, asynchronous):
  - signals_o = RESET_VALUE; synchroniser flops = RESET_VALUE.
  - rise_o, fall_o, changed_o, glitch_o = 0.
  - Prescaler = 0; all channel counters = 0.
- Synchroniser: SYNC_STAGES flops per channel; the last stage is sync[i].
- Prescaler:
  - If SAMPLE_DIV ≤ 1, tick = enable_i.
  - Otherwise the counter runs 0..SAMPLE_DIV-1, advancing only while enable_i is high. tick = enable_i && count == SAMPLE_DIV-1; the counter wraps to 0 on that cycle.
- Per channel, counter width $clog2(STABLE_SAMPLES+1). On tick:
  - sync[i] == signals_o[i]: cnt ← 0. If cnt was non-zero, glitch_o[i] ← 1.
  - sync[i] != signals_o[i] and cnt+1 < STABLE_SAMPLES: cnt ← cnt+1.
  - sync[i] != signals_o[i] and cnt+1 == STABLE_SAMPLES:
    - signals_o[i] ← sync[i]; cnt ← 0.
    - rise_o[i] or fall_o[i] pulses according to the new level.
- No tick: cnt and signals_o hold; rise_o, fall_o and changed_o are 0.
- STABLE_SAMPLES = 1: the output follows sync[i] at every tick, and glitch_o can never set.
- glitch_o: if set and clear_i coincide on the same cycle, set wins. Otherwise clear_i low-to-high clears all bits on the next edge.
- enable_i low mid-count: counts are preserved. Counting resumes exactly where it stopped; no partial tick is lost or added.
- Channels are fully independent. Simultaneous transitions on several channels each produce their own pulse; changed_o is a single pulse.

## Timing
- All outputs are registered. Edge pulses are exactly 1 clk wide, asserted in the same cycle as the signals_o update.
- Input-to-output latency with an input stable from clock t, enable_i held high:
  - Minimum: SYNC_STAGES + (STABLE_SAMPLES-1)·SAMPLE_DIV + 1 clocks.
  - Maximum: SYNC_STAGES + STABLE_SAMPLES·SAMPLE_DIV clocks.
- A bounce shorter than (STABLE_SAMPLES-1)·SAMPLE_DIV clocks never reaches signals_o.
- Reset release: first tick SAMPLE_DIV clocks after nReset_i deasserts, given enable_i high.
- Reset mid-count: the count is discarded and the output returns to RESET_VALUE immediately, with no pulse emitted.

## Test plan
All scenarios use NUMBER_SIGNALS=4, CLOCK_PERIOD_NS=20, SAMPLE_PERIOD_NS=100 (SAMPLE_DIV=5), STABLE_SAMPLES=3, SYNC_STAGES=2, RESET_VALUE=4'b1111.
- Reset/idle: hold signals_i=4'hF after reset → signals_o=4'hF, all pulses 0 and glitch_o=0 for 100 clks.
- Clean edge: drop signals_i[0] to 0 and hold → signals_o[0] falls within 13–17 clks; fall_o[0] and changed_o each high exactly 1 clk; rise_o stays 0.
- Bounce rejection: on ch1 toggle 0 for 7 clks, then back to 1 → signals_o[1] stays 1 and glitch_o[1]=1. clear_i pulse → glitch_o=0.
- Simultaneous: ch2 and ch3 fall on the same clk → both fall_o bits pulse in the same cycle, with a single changed_o pulse.
- Enable freeze: drop ch0, deassert enable_i for 50 clks after 2 ticks → no output change while disabled; change occurs 1 tick after re-enable.
- Async reset mid-count: assert nReset_i between the 2nd and 3rd ticks of a pending fall → signals_o=4'hF immediately; no fall_o pulse; the count restarts from 0 after release.
